timer_core: RTL and testbench

//  Counting engine downstream of the timer APB register block. Consumes MODE, GO_EN, TOT_CNT and

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_if.sv | 23 ++
 rtl/timer_prescaler.sv | 32 +++
 rtl/timer_core.sv | 119 +++++++++++
 tb/tb_timer_core.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding and mode constants for the timer counting engine.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_if.sv
// Control/status bundle between the APB register block (master) and timer_core (slave).
interface timer_if #(
    parameter int CNT_W = 32
) ();
    logic             MODE;
    logic             GO_EN;
    logic [CNT_W-1:0] TOT_CNT;
    logic [CNT_W-1:0] DUTY_CNT;
    logic             IRQ_TRG;
    logic             PWM_OUT;
    logic [CNT_W-1:0] CNT_VAL;
    logic             BUSY;

    modport master (
        output MODE, GO_EN, TOT_CNT, DUTY_CNT,
        input  IRQ_TRG, PWM_OUT, CNT_VAL, BUSY
    );

    modport slave (
        input  MODE, GO_EN, TOT_CNT, DUTY_CNT,
        output IRQ_TRG, PWM_OUT, CNT_VAL, BUSY
    );
endinterface

// File: rtl/timer_prescaler.sv
// Tick strobe generator: one-cycle pulse every PSC_DIV clocks, restartable via clr.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
    parameter int PSC_DIV = 4
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    output logic tick
);
    localparam int PSC_W = (PSC_DIV > 1) ? $clog2(PSC_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PSC_DIV - 1);

    logic [PSC_W-1:0] psc_q, psc_d;

    assign tick = (psc_q == PSC_LAST);

    always_comb begin
        psc_d = psc_q + 1'b1;
        if (clr || tick) begin
            psc_d = '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
endmodule

// File: rtl/timer_core.sv
// Timer counting engine: IDLE/RUN/DONE FSM, period counter, PWM compare and IRQ pulse.
// Optional tick prescaler selected by defining TIMER_PRESCALE_EN.
module timer_core
    import timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PSC_DIV = 4
) (
    input  logic   PCLK,
    input  logic   PRESET,
    timer_if.slave tif
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tot_sh_q, tot_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             irq_q, irq_d;
    logic             pwm_q, pwm_d;
    logic             tick;
    logic [CNT_W-1:0] tot_load;

`ifdef TIMER_PRESCALE_EN
    logic psc_clr;

    // Prescaler restarts whenever we are not actively running, covering both start and abort.
    assign psc_clr = (state_q != ST_RUN) || !tif.GO_EN;

    timer_prescaler #(
        .PSC_DIV (PSC_DIV)
    ) u_prescaler (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clr    (psc_clr),
        .tick   (tick)
    );
`else
    logic unused_psc;

    assign tick       = 1'b1;
    assign unused_psc = (PSC_DIV >= 1);
`endif

    // A zero period would never reach its terminal tick, so treat it as one tick.
    assign tot_load = (tif.TOT_CNT == '0) ? CNT_W'(1) : tif.TOT_CNT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tot_sh_d  = tot_sh_q;
        duty_sh_d = duty_sh_q;
        irq_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tif.GO_EN) begin
                    tot_sh_d  = tot_load;
                    duty_sh_d = tif.DUTY_CNT;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!tif.GO_EN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == tot_sh_q - CNT_W'(1)) begin
                        irq_d = 1'b1;
                        if (tif.MODE == MODE_PERIODIC) begin
                            cnt_d     = '0;
                            tot_sh_d  = tot_load;
                            duty_sh_d = tif.DUTY_CNT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!tif.GO_EN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Computed from next-state values so the registered PWM lines up with CNT_VAL.
        pwm_d = (state_d == ST_RUN) && (cnt_d < duty_sh_d);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tot_sh_q  <= '0;
            duty_sh_q <= '0;
            irq_q     <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tot_sh_q  <= tot_sh_d;
            duty_sh_q <= duty_sh_d;
            irq_q     <= irq_d;
            pwm_q     <= pwm_d;
        end
    end

    assign tif.IRQ_TRG = irq_q;
    assign tif.PWM_OUT = pwm_q;
    assign tif.CNT_VAL = cnt_q;
    assign tif.BUSY    = (state_q == ST_RUN);
endmodule

// File: tb/tb_timer_core.sv
// Scoreboard bench for timer_core: stimulus queues per-cycle expectations, a monitor checks them.
module tb_timer_core;
    logic clk;
    logic rst;

    timer_if #(.CNT_W(32)) bus ();

    timer_core #(
        .CNT_W   (32),
        .PSC_DIV (4)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .tif    (bus)
    );

    typedef struct {
        string       name;
        logic        pwm;
        logic        irq;
        logic        busy;
        logic [31:0] cnt;
        bit          chk_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    logic        mode_v;
    logic [31:0] tot_v;
    logic [31:0] duty_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: outputs after each rising edge are checked against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d %s: pwm=%0b irq=%0b busy=%0b cnt=%0d", n_txn, e.name,
                         bus.PWM_OUT, bus.IRQ_TRG, bus.BUSY, bus.CNT_VAL);
                chk({e.name, ".pwm"},  {31'd0, bus.PWM_OUT}, {31'd0, e.pwm});
                chk({e.name, ".irq"},  {31'd0, bus.IRQ_TRG}, {31'd0, e.irq});
                chk({e.name, ".busy"}, {31'd0, bus.BUSY},    {31'd0, e.busy});
                if (e.chk_cnt) begin
                    chk({e.name, ".cnt"}, bus.CNT_VAL, e.cnt);
                end
            end
        end
    end

    // Drive one cycle of inputs; the expectation applies after the edge that samples them.
    task automatic step(input logic r, input logic g, input string nm, input logic e_pwm,
                        input logic e_irq, input logic e_busy, input logic [31:0] e_cnt,
                        input bit chk_cnt);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.GO_EN    = g;
        bus.MODE     = mode_v;
        bus.TOT_CNT  = tot_v;
        bus.DUTY_CNT = duty_v;
        e.name    = nm;
        e.pwm     = e_pwm;
        e.irq     = e_irq;
        e.busy    = e_busy;
        e.cnt     = e_cnt;
        e.chk_cnt = chk_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        rst          = 1'b1;
        mode_v       = 1'b0;
        tot_v        = 32'd0;
        duty_v       = 32'd0;
        bus.GO_EN    = 1'b0;
        bus.MODE     = 1'b0;
        bus.TOT_CNT  = 32'd0;
        bus.DUTY_CNT = 32'd0;

        step(1, 0, "reset", 0, 0, 0, 0, 1);
        step(1, 1, "reset_go", 0, 0, 0, 0, 1);
        step(0, 0, "idle", 0, 0, 0, 0, 1);

`ifdef TIMER_PRESCALE_EN
        // Divide-by-4 ticks: each count lasts 4 cycles, period of 2 counts = 8 cycles.
        mode_v = 1'b1; tot_v = 32'd2; duty_v = 32'd1;
        step(0, 1, "psc_start", 1, 0, 1, 0, 1);
        for (int k = 1; k < 24; k++) begin
            step(0, 1, "psc_run", ((k / 4) % 2) == 0, (k % 8) == 0, 1, 32'((k / 4) % 2), 1);
        end
        step(0, 0, "psc_abort", 0, 0, 0, 0, 1);
`else
        // Periodic TOT=4 DUTY=1; final stop lands on a terminal tick, so no IRQ.
        mode_v = 1'b1; tot_v = 32'd4; duty_v = 32'd1;
        step(0, 1, "per_start", 1, 0, 1, 0, 1);
        for (int k = 1; k < 12; k++) begin
            step(0, 1, "per_run", (k % 4) < 1, (k % 4) == 0, 1, 32'(k % 4), 1);
        end
        step(0, 0, "abort_terminal", 0, 0, 0, 0, 1);
        step(0, 0, "idle", 0, 0, 0, 0, 1);

        // One-shot TOT=5 DUTY=2.
        mode_v = 1'b0; tot_v = 32'd5; duty_v = 32'd2;
        step(0, 1, "os_start", 1, 0, 1, 0, 1);
        for (int k = 1; k < 5; k++) begin
            step(0, 1, "os_run", k < 2, 0, 1, 32'(k), 1);
        end
        step(0, 1, "os_irq_done", 0, 1, 0, 0, 0);
        step(0, 1, "os_done_hold", 0, 0, 0, 0, 0);
        step(0, 0, "os_to_idle", 0, 0, 0, 0, 1);
        step(0, 0, "idle", 0, 0, 0, 0, 1);

        // DUTY=0: never high.
        mode_v = 1'b1; tot_v = 32'd4; duty_v = 32'd0;
        step(0, 1, "d0_start", 0, 0, 1, 0, 1);
        for (int k = 1; k < 8; k++) begin
            step(0, 1, "d0_run", 0, (k % 4) == 0, 1, 32'(k % 4), 1);
        end
        step(0, 0, "d0_abort", 0, 0, 0, 0, 1);

        // DUTY=7 > TOT=4: constant high while running.
        duty_v = 32'd7;
        step(0, 1, "d7_start", 1, 0, 1, 0, 1);
        for (int k = 1; k < 8; k++) begin
            step(0, 1, "d7_run", 1, (k % 4) == 0, 1, 32'(k % 4), 1);
        end
        step(0, 0, "d7_abort", 0, 0, 0, 0, 1);

        // TOT=0 coerced to 1: IRQ every cycle.
        tot_v = 32'd0; duty_v = 32'd0;
        step(0, 1, "t0_start", 0, 0, 1, 0, 1);
        for (int k = 1; k < 5; k++) begin
            step(0, 1, "t0_run", 0, 1, 1, 0, 1);
        end
        step(0, 0, "t0_abort", 0, 0, 0, 0, 1);

        // Abort at cnt=2 of TOT=8.
        tot_v = 32'd8; duty_v = 32'd4;
        step(0, 1, "ab_start", 1, 0, 1, 0, 1);
        step(0, 1, "ab_run", 1, 0, 1, 1, 1);
        step(0, 1, "ab_run", 1, 0, 1, 2, 1);
        step(0, 0, "ab_abort", 0, 0, 0, 0, 1);
        step(0, 0, "idle", 0, 0, 0, 0, 1);

        // Reload: TOT 4->6 mid-period takes effect only at the boundary.
        tot_v = 32'd4; duty_v = 32'd2;
        step(0, 1, "rl_start", 1, 0, 1, 0, 1);
        step(0, 1, "rl_run4", 1, 0, 1, 1, 1);
        tot_v = 32'd6;
        step(0, 1, "rl_run4", 0, 0, 1, 2, 1);
        step(0, 1, "rl_run4", 0, 0, 1, 3, 1);
        step(0, 1, "rl_wrap", 1, 1, 1, 0, 1);
        for (int k = 1; k < 6; k++) begin
            step(0, 1, "rl_run6", k < 2, 0, 1, 32'(k), 1);
        end
        step(0, 1, "rl_wrap6", 1, 1, 1, 0, 1);
        step(0, 1, "rl_run6", 1, 0, 1, 1, 1);
        step(1, 1, "rl_reset", 0, 0, 0, 0, 1);
        step(0, 0, "idle", 0, 0, 0, 0, 1);
`endif

        step(0, 0, "idle_end", 0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
